// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
// State encoding, reset PC default, halt word, and word-alignment helper.
package fetch_pkg;

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } fetch_state_t;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] INSTR_HALT       = 32'h0000_0000;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & ~32'h3;
    endfunction

endpackage

// File: rtl/fetch_pc_gen.sv
// Next-PC mux: redirect > increment > hold, wrapped to the memory span, word aligned.
// Purely combinational (0 cycles); backpressure arrives via the incr qualifier only.
module fetch_pc_gen
    import fetch_pkg::*;
#(
    parameter int IMEM_WORDS = 1024
) (
    input  logic [31:0] pc,
    input  logic        redirect,
    input  logic [31:0] target,
    input  logic        incr,
    output logic [31:0] next_pc
);

    localparam logic [31:0] PC_SPAN = 32'(IMEM_WORDS) << 2;
    localparam logic [31:0] PC_LAST = PC_SPAN - 32'd4;

    always_comb begin
        next_pc = pc;
        if (redirect) begin
            next_pc = word_align(target) % PC_SPAN;
        end else if (incr) begin
            next_pc = (pc == PC_LAST) ? 32'd0 : pc + 32'd4;
        end
    end

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: owns PC, registers imem word into IF/ID; 1-cycle PC->instr_out latency.
// Backpressure: ready_in low or stall freezes PC and IF/ID; FETCH_MISALIGN_CHECK_EN adds sticky misalign_err.
module instruction_fetch
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
    parameter int          IMEM_WORDS = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rd,
    output logic [31:0] instr_out,
    output logic [31:0] pc_out,
    output logic        valid_out,
    input  logic        ready_in,
    output logic        halted,
    output logic [31:0] fetch_count,
    output logic        misalign_err
);

    fetch_state_t state, next_state;
    logic [31:0]  pc, next_pc;
    logic         advance, zero_word, capture, accept;

    assign advance   = (state == ST_RUN) && !stall && (!valid_out || ready_in);
    assign zero_word = (imem_rd == INSTR_HALT);
    assign capture   = advance && !branch_taken && !zero_word;
    assign accept    = valid_out && ready_in && !branch_taken && !stall;
    assign imem_addr = pc;

    fetch_pc_gen #(.IMEM_WORDS(IMEM_WORDS)) u_pc_gen (
        .pc       (pc),
        .redirect (branch_taken),
        .target   (branch_target),
        .incr     (capture),
        .next_pc  (next_pc)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= ST_BOOT;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_BOOT: next_state = ST_RUN;
            ST_RUN:  if (advance && zero_word) next_state = ST_HALT;
            ST_HALT: next_state = ST_HALT;
            default: next_state = ST_BOOT;
        endcase
        // A redirect restarts fetch from any state, including HALT.
        if (branch_taken) next_state = ST_RUN;
    end

    always_comb begin
        halted = (state == ST_HALT);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc        <= RESET_PC;
            instr_out <= '0;
            pc_out    <= '0;
            valid_out <= 1'b0;
        end else begin
            pc <= next_pc;
            if (branch_taken) begin
                valid_out <= 1'b0;
            end else if (!stall) begin
                if (capture) begin
                    instr_out <= imem_rd;
                    pc_out    <= pc;
                    valid_out <= 1'b1;
                end else if (advance || (valid_out && ready_in)) begin
                    valid_out <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)      fetch_count <= '0;
        else if (accept) fetch_count <= fetch_count + 32'd1;
    end

`ifdef FETCH_MISALIGN_CHECK_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                                   misalign_err <= 1'b0;
        else if (branch_taken && |branch_target[1:0]) misalign_err <= 1'b1;
    end
`else
    assign misalign_err = 1'b0;
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// Scoreboarded bench for instruction_fetch: expected accepted (instr, pc) pairs are
// queued as stimulus is set up and retired by a handshake monitor.
module tb_instruction_fetch;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } acc_t;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic [31:0] imem_addr;
    logic [31:0] imem_rd;
    logic [31:0] instr_out;
    logic [31:0] pc_out;
    logic        valid_out;
    logic        ready_in;
    logic        halted;
    logic [31:0] fetch_count;
    logic        misalign_err;

    logic [31:0] mem [0:1023];
    acc_t        exp_q [$];
    int          n_tests = 0;
    int          n_fail  = 0;

    instruction_fetch #(.RESET_PC(32'h0), .IMEM_WORDS(1024)) dut (
        .clk           (clk),
        .reset         (reset),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .imem_addr     (imem_addr),
        .imem_rd       (imem_rd),
        .instr_out     (instr_out),
        .pc_out        (pc_out),
        .valid_out     (valid_out),
        .ready_in      (ready_in),
        .halted        (halted),
        .fetch_count   (fetch_count),
        .misalign_err  (misalign_err)
    );

    assign imem_rd = mem[imem_addr[11:2]];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int idx);
        acc_t e;
        e.instr = mem[idx];
        e.pc    = 32'(idx) << 2;
        exp_q.push_back(e);
    endtask

    // Retire one expected pair on every handshake decode will actually take.
    always @(negedge clk) begin
        if (reset && valid_out && ready_in && !stall && !branch_taken) begin
            check("acc_q_nonempty", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                acc_t e;
                e = exp_q.pop_front();
                check("acc_instr", instr_out, e.instr);
                check("acc_pc", pc_out, e.pc);
            end
        end
    end

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 32'hA000_0000 | 32'(i);
        mem[0] = 32'h0050_2223;
        mem[1] = 32'h0060_2423;
        mem[2] = 32'h0070_2623;
        mem[3] = 32'h0000_0000;

        reset = 1'b0; stall = 1'b0; branch_taken = 1'b0;
        branch_target = 32'h0; ready_in = 1'b1;
        #2;
        check("rst_imem_addr", imem_addr, 32'h0);
        check("rst_valid", 32'(valid_out), 32'd0);
        check("rst_instr", instr_out, 32'h0);
        check("rst_pc_out", pc_out, 32'h0);
        check("rst_halted", 32'(halted), 32'd0);
        check("rst_count", fetch_count, 32'h0);
        check("rst_misalign", 32'(misalign_err), 32'd0);

        // Boot and run into the zero word at 0xC.
        tick();
        reset = 1'b1;
        push(0); push(1); push(2);
        tick();
        check("boot_valid", 32'(valid_out), 32'd0);
        check("boot_addr", imem_addr, 32'h0);
        tick();
        check("w0_valid", 32'(valid_out), 32'd1);
        check("w0_pc", pc_out, 32'h0);
        tick();
        check("w1_pc", pc_out, 32'h4);
        tick();
        check("w2_pc", pc_out, 32'h8);
        check("w2_addr", imem_addr, 32'hC);
        tick();
        check("halt_flag", 32'(halted), 32'd1);
        check("halt_valid", 32'(valid_out), 32'd0);
        check("halt_count", fetch_count, 32'd3);
        tick();
        check("halt_addr_hold", imem_addr, 32'hC);

        // Backpressure: redirect out of HALT, then hold the word for 3 cycles.
        branch_taken = 1'b1; branch_target = 32'h10; ready_in = 1'b0;
        tick();
        check("redir_addr", imem_addr, 32'h10);
        check("redir_halted", 32'(halted), 32'd0);
        branch_taken = 1'b0;
        tick();
        check("bp_pc_out", pc_out, 32'h10);
        for (int i = 0; i < 3; i++) tick();
        check("bp_hold_pc", pc_out, 32'h10);
        check("bp_hold_instr", instr_out, mem[4]);
        check("bp_hold_addr", imem_addr, 32'h14);
        check("bp_hold_count", fetch_count, 32'd3);
        push(4); push(5);
        ready_in = 1'b1;
        tick();
        check("resume_pc1", pc_out, 32'h14);
        tick();
        check("resume_pc2", pc_out, 32'h18);
        check("resume_count", fetch_count, 32'd5);

        // Redirect while a word is being accepted: it is flushed, not counted.
        branch_taken = 1'b1; branch_target = 32'h8;
        tick();
        branch_taken = 1'b0;
        check("flush_valid", 32'(valid_out), 32'd0);
        check("flush_addr", imem_addr, 32'h8);
        check("flush_count", fetch_count, 32'd5);
        push(2);
        tick();
        check("tgt_valid", 32'(valid_out), 32'd1);
        check("tgt_pc", pc_out, 32'h8);
        tick();
        check("halt2_flag", 32'(halted), 32'd1);
        check("halt2_count", fetch_count, 32'd6);

        // Stall and redirect together: redirect wins.
        stall = 1'b1; branch_taken = 1'b1; branch_target = 32'h20;
        tick();
        branch_taken = 1'b0;
        check("stall_br_addr", imem_addr, 32'h20);
        check("stall_br_halted", 32'(halted), 32'd0);
        tick(); tick();
        check("stall_freeze_addr", imem_addr, 32'h20);
        check("stall_freeze_valid", 32'(valid_out), 32'd0);
        stall = 1'b0; ready_in = 1'b0;
        tick();
        check("stall_cap_pc", pc_out, 32'h20);
        stall = 1'b1; ready_in = 1'b1;
        tick(); tick();
        check("stall_rdy_pc", pc_out, 32'h20);
        check("stall_rdy_count", fetch_count, 32'd6);
        check("stall_rdy_addr", imem_addr, 32'h24);
        push(8);
        stall = 1'b0;
        tick();
        ready_in = 1'b0;
        check("unstall_pc", pc_out, 32'h24);
        check("unstall_count", fetch_count, 32'd7);

        // Wrap at the top of instruction memory.
        branch_taken = 1'b1; branch_target = 32'hFFC;
        tick();
        branch_taken = 1'b0;
        check("wrap_top_addr", imem_addr, 32'hFFC);
        tick();
        check("wrap_next_addr", imem_addr, 32'h0);
        check("wrap_pc_out", pc_out, 32'hFFC);
        push(1023);
        ready_in = 1'b1;
        tick();
        ready_in = 1'b0;
        check("wrap_instr0", instr_out, mem[0]);
        check("wrap_pc0", pc_out, 32'h0);
        check("wrap_count", fetch_count, 32'd8);

        // Misaligned redirect.
        branch_taken = 1'b1; branch_target = 32'h6;
        tick();
        branch_taken = 1'b0;
        check("mis_addr", imem_addr, 32'h4);
`ifdef FETCH_MISALIGN_CHECK_EN
        check("mis_flag", 32'(misalign_err), 32'd1);
`else
        check("mis_flag_off", 32'(misalign_err), 32'd0);
`endif
        branch_taken = 1'b1; branch_target = 32'h40;
        tick();
        branch_taken = 1'b0;
        check("mis_aligned_addr", imem_addr, 32'h40);
`ifdef FETCH_MISALIGN_CHECK_EN
        check("mis_sticky", 32'(misalign_err), 32'd1);
`else
        check("mis_sticky_off", 32'(misalign_err), 32'd0);
`endif

        // Asynchronous reset mid-run drops the presented word.
        ready_in = 1'b1;
        tick();
        check("pre_rst_valid", 32'(valid_out), 32'd1);
        #2;
        reset = 1'b0;
        #1;
        check("arst_valid", 32'(valid_out), 32'd0);
        check("arst_addr", imem_addr, 32'h0);
        check("arst_count", fetch_count, 32'd0);
        check("arst_pc_out", pc_out, 32'h0);
        check("arst_misalign", 32'(misalign_err), 32'd0);
        ready_in = 1'b0;
        tick();
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
